// File: rtl/cnt10_seq_pkg.sv
// Shared types and helpers for the CNT10 cascade run controller.
package cnt10_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_PAUSE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic bcd_nibble_ok(input logic [3:0] nibble);
        return nibble <= BCD_MAX;
    endfunction

endpackage

// File: rtl/cnt10_en_chain.sv
// Ripple enable chain: digit i counts only when every lower digit sits at 9.
module cnt10_en_chain
    import cnt10_seq_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic              go,
    input  logic [DIGITS-1:0] COUT_IN,
    output logic [DIGITS-1:0] CNT_EN
);

    logic carry;

    always_comb begin
        carry  = go;
        CNT_EN = '0;
        for (int i = 0; i < DIGITS; i++) begin
            CNT_EN[i] = carry;
            carry     = carry & COUT_IN[i];
        end
    end

endmodule

// File: rtl/cnt10_seq.sv
// Run controller for a cascade of CNT10 decade counters (preset, count, stop on target).
// Optional feature: define CNT10_SEQ_AUTORELOAD_EN to reload the preset on every match.
module cnt10_seq
    import cnt10_seq_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic                STOP,
    input  logic                CLEAR,
    input  logic [4*DIGITS-1:0] PRESET,
    input  logic [4*DIGITS-1:0] TARGET,
    input  logic [4*DIGITS-1:0] DOUT_IN,
    input  logic [DIGITS-1:0]   COUT_IN,
    output logic [DIGITS-1:0]   CNT_EN,
    output logic                CNT_LOAD_N,
    output logic                CNT_RST_N,
    output logic [4*DIGITS-1:0] CNT_DATA,
    output logic                BUSY,
    output logic                DONE,
    output logic                ERR,
    output logic [2:0]          STATE
);

    localparam int W = 4 * DIGITS;

    state_t         state, state_nx;
    logic [W-1:0]   preset_reg, target_reg;
    logic           err_reg;
    logic           inputs_ok, accept, reject, match, run_go, done_any;
    logic [DIGITS-1:0] run_en;
`ifdef CNT10_SEQ_AUTORELOAD_EN
    logic           reload, reload_pulse;
`endif

    always_comb begin
        inputs_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_nibble_ok(PRESET[4*i +: 4]) || !bcd_nibble_ok(TARGET[4*i +: 4]))
                inputs_ok = 1'b0;
        end
    end

    assign match  = (DOUT_IN == target_reg);
    // STOP/CLEAR freeze the chain in the same cycle they are seen.
    assign run_go = (state == S_RUN) && !match && !STOP && !CLEAR;

    cnt10_en_chain #(.DIGITS(DIGITS)) u_en_chain (
        .go      (run_go),
        .COUT_IN (COUT_IN),
        .CNT_EN  (run_en)
    );

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        reject   = 1'b0;
`ifdef CNT10_SEQ_AUTORELOAD_EN
        reload   = 1'b0;
`endif
        if (CLEAR) begin
            state_nx = S_CLR;
        end else begin
            case (state)
                S_CLR:  state_nx = S_IDLE;
                S_IDLE, S_DONE: begin
                    if (START && !STOP) begin
                        if (inputs_ok) begin
                            state_nx = S_LOAD;
                            accept   = 1'b1;
                        end else begin
                            reject   = 1'b1;
                        end
                    end
                end
                S_LOAD: state_nx = S_RUN;
                S_RUN: begin
                    if (match) begin
`ifdef CNT10_SEQ_AUTORELOAD_EN
                        if (STOP) begin
                            state_nx = S_DONE;
                        end else begin
                            state_nx = S_LOAD;
                            reload   = 1'b1;
                        end
`else
                        state_nx = S_DONE;
`endif
                    end else if (STOP) begin
                        state_nx = S_PAUSE;
                    end
                end
                S_PAUSE: if (START && !STOP) state_nx = S_RUN;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            err_reg    <= 1'b0;
            preset_reg <= '0;
            target_reg <= '0;
        end else begin
            state   <= state_nx;
            err_reg <= reject;
            if (accept) begin
                preset_reg <= PRESET;
                target_reg <= TARGET;
            end
        end
    end

`ifdef CNT10_SEQ_AUTORELOAD_EN
    always_ff @(posedge CLK) begin
        if (RST) reload_pulse <= 1'b0;
        else     reload_pulse <= reload;
    end
    assign done_any = (state == S_DONE) || reload_pulse;
`else
    assign done_any = (state == S_DONE);
`endif

    // Counter-facing outputs are forced safe while RST is high.
    always_comb begin
        CNT_EN = '0;
        if (!RST) begin
            case (state)
                S_LOAD:  CNT_EN = '1;
                S_RUN:   CNT_EN = run_en;
                default: CNT_EN = '0;
            endcase
        end
    end

    assign CNT_LOAD_N = RST || (state != S_LOAD);
    assign CNT_RST_N  = !(RST || (state == S_CLR));
    assign CNT_DATA   = RST ? '0 : preset_reg;
    assign BUSY       = !RST && ((state == S_LOAD) || (state == S_RUN) || (state == S_PAUSE));
    assign DONE       = !RST && done_any;
    assign ERR        = !RST && err_reg;
    assign STATE      = state;

endmodule
